// File: rtl/stream_mux_pkg.sv
// Shared constants for the stream multiplexer: mode encodings and default geometry.
package stream_mux_pkg;

    localparam int unsigned DEF_NUM_IN = 4;
    localparam int unsigned DEF_WIDTH  = 8;
    localparam int unsigned DEF_SEL_W  = 2;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    // Channel index reached by stepping 'off' positions past 'base', modulo n.
    function automatic int unsigned wrap_idx(input int unsigned base,
                                             input int unsigned off,
                                             input int unsigned n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester after ptr, wrapping modulo NUM_IN.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int unsigned NUM_IN = DEF_NUM_IN,
    parameter int unsigned SEL_W  = DEF_SEL_W
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    input  logic              enable,
    output logic [NUM_IN-1:0] grant_c,
    output logic [SEL_W-1:0]  grant_idx_c,
    output logic              grant_valid_c
);

    int unsigned cand;

    // Search ptr+1 .. ptr+NUM_IN; the last step revisits ptr itself.
    always_comb begin
        grant_c       = '0;
        grant_idx_c   = '0;
        grant_valid_c = 1'b0;
        cand          = 0;
        for (int unsigned k = 1; k <= NUM_IN; k++) begin
            cand = wrap_idx(32'(ptr), k, NUM_IN);
            if (enable && !grant_valid_c && req[cand]) begin
                grant_valid_c = 1'b1;
                grant_idx_c   = SEL_W'(cand);
                grant_c[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux.sv
// N-input valid/ready multiplexer with explicit-select or round-robin arbitration
// feeding a one-entry registered output stage.
module stream_mux
    import stream_mux_pkg::*;
#(
    parameter int unsigned NUM_IN = DEF_NUM_IN,
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned SEL_W  = DEF_SEL_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rr_mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN-1:0]       in_valid,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic [NUM_IN-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_chan,
    input  logic                    out_ready
);

    logic [SEL_W-1:0]  rr_ptr;

    logic [NUM_IN-1:0] arb_grant_c;
    logic [SEL_W-1:0]  arb_idx_c;
    logic              arb_valid_c;

    logic              sel_hit_c;
    logic [NUM_IN-1:0] grant_oh_c;
    logic [SEL_W-1:0]  grant_idx_c;
    logic              grant_valid_c;
    logic              can_load_c;
    logic              xfer_c;

    rr_arbiter #(
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_arb (
        .req           (in_valid),
        .ptr           (rr_ptr),
        .enable        (rr_mode == MODE_RR),
        .grant_c       (arb_grant_c),
        .grant_idx_c   (arb_idx_c),
        .grant_valid_c (arb_valid_c)
    );

    // Select mode: an out-of-range index simply grants nothing.
    always_comb begin
        sel_hit_c = 1'b0;
        if (32'(sel) < NUM_IN) begin
            sel_hit_c = in_valid[sel];
        end
    end

    always_comb begin
        grant_oh_c    = '0;
        grant_idx_c   = '0;
        grant_valid_c = 1'b0;
        if (rr_mode == MODE_RR) begin
            grant_oh_c    = arb_grant_c;
            grant_idx_c   = arb_idx_c;
            grant_valid_c = arb_valid_c;
        end else if (sel_hit_c) begin
            grant_oh_c    = NUM_IN'(1) << sel;
            grant_idx_c   = sel;
            grant_valid_c = 1'b1;
        end
    end

    // The output slot may refill in the same cycle it drains.
    assign can_load_c = !out_valid || out_ready;
    assign xfer_c     = can_load_c && grant_valid_c && !reset;
    assign in_ready   = xfer_c ? grant_oh_c : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            rr_ptr    <= SEL_W'(NUM_IN - 1);
        end else if (xfer_c) begin
            out_valid <= 1'b1;
            out_data  <= in_data[32'(grant_idx_c)*WIDTH +: WIDTH];
            out_chan  <= grant_idx_c;
            rr_ptr    <= grant_idx_c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux.sv
// Directed self-checking bench for stream_mux: a 4-channel instance for the main
// behaviour and a 3-channel instance for out-of-range select and pointer wrap.
module tb_stream_mux;

    logic        clk;
    logic        reset;

    logic        rr_mode;
    logic [1:0]  sel;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_chan;
    logic        out_ready;

    logic        rr3;
    logic [1:0]  sel3;
    logic [2:0]  v3;
    logic [23:0] d3;
    logic [2:0]  rdy3;
    logic        ov3;
    logic [7:0]  od3;
    logic [1:0]  oc3;
    logic        ordy3;

    int checks;
    int failures;

    stream_mux #(.NUM_IN(4), .WIDTH(8), .SEL_W(2)) u_dut4 (
        .clk       (clk),
        .reset     (reset),
        .rr_mode   (rr_mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_ready (out_ready)
    );

    stream_mux #(.NUM_IN(3), .WIDTH(8), .SEL_W(2)) u_dut3 (
        .clk       (clk),
        .reset     (reset),
        .rr_mode   (rr3),
        .sel       (sel3),
        .in_valid  (v3),
        .in_data   (d3),
        .in_ready  (rdy3),
        .out_valid (ov3),
        .out_data  (od3),
        .out_chan  (oc3),
        .out_ready (ordy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        logic [1:0] ec;
        logic [7:0] ed;
        checks   = 0;
        failures = 0;

        // Reset held two cycles with every channel valid.
        reset     = 1'b1;
        rr_mode   = 1'b1;
        sel       = 2'd0;
        in_valid  = 4'b1111;
        in_data   = {8'h40, 8'h30, 8'h20, 8'h10};
        out_ready = 1'b1;
        rr3 = 1'b0; sel3 = 2'd0; v3 = 3'b000; d3 = {8'h0C, 8'h0B, 8'h0A}; ordy3 = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data",  32'(out_data),  32'h00);
        chk("rst_out_chan",  32'(out_chan),  32'h0);
        chk("rst_in_ready",  32'(in_ready),  32'h0);
        chk("rst3_out_valid", 32'(ov3), 32'h0);

        // Release: round-robin starts at channel 0.
        reset = 1'b0;
        settle();
        chk("rr_first_ready", 32'(in_ready), 32'b0001);
        tick();
        chk("rr_first_valid", 32'(out_valid), 32'h1);
        chk("rr_first_chan",  32'(out_chan),  32'h0);
        chk("rr_first_data",  32'(out_data),  32'h10);

        // Remaining seven beats of the 0,1,2,3,0,1,2,3 rotation.
        for (int i = 1; i < 8; i++) begin
            ec = 2'(i % 4);
            ed = 8'((i % 4 + 1) * 16);
            chk("rr_seq_ready", 32'(in_ready), 32'(4'b0001 << ec));
            tick();
            chk("rr_seq_chan", 32'(out_chan), 32'(ec));
            chk("rr_seq_data", 32'(out_data), 32'(ed));
        end

        // Select mode.
        rr_mode = 1'b0;
        sel     = 2'd2;
        settle();
        chk("sel2_ready", 32'(in_ready), 32'b0100);
        tick();
        chk("sel2_data", 32'(out_data), 32'h30);
        chk("sel2_chan", 32'(out_chan), 32'h2);
        sel = 2'd3;
        settle();
        chk("sel3_ready", 32'(in_ready), 32'b1000);
        tick();
        chk("sel3_data", 32'(out_data), 32'h40);
        chk("sel3_chan", 32'(out_chan), 32'h3);

        // Sparse round-robin over channels 1 and 3 (pointer is 3).
        rr_mode  = 1'b1;
        in_valid = 4'b1010;
        settle();
        for (int i = 0; i < 5; i++) begin
            ec = (i % 2 == 0) ? 2'd1 : 2'd3;
            tick();
            chk("sparse_chan", 32'(out_chan), 32'(ec));
        end

        // Pointer now 1; with only channel 1 left it is granted again.
        in_valid = 4'b0010;
        settle();
        chk("drop3_ready", 32'(in_ready), 32'b0010);
        tick();
        chk("drop3_chan", 32'(out_chan), 32'h1);
        chk("drop3_data", 32'(out_data), 32'h20);

        // Backpressure: held beat stays put while modes and select wander.
        out_ready = 1'b0;
        in_valid  = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            rr_mode = 1'(i % 2);
            sel     = 2'(i);
            settle();
            chk("bp_ready", 32'(in_ready), 32'h0);
            tick();
            chk("bp_valid", 32'(out_valid), 32'h1);
            chk("bp_chan",  32'(out_chan),  32'h1);
            chk("bp_data",  32'(out_data),  32'h20);
        end
        rr_mode   = 1'b1;
        out_ready = 1'b1;
        settle();
        chk("bp_release_ready", 32'(in_ready), 32'b0100);
        tick();
        chk("bp_release_valid", 32'(out_valid), 32'h1);
        chk("bp_release_chan",  32'(out_chan),  32'h2);
        chk("bp_release_data",  32'(out_data),  32'h30);

        // Drain with no requesters.
        in_valid = 4'b0000;
        settle();
        chk("idle_ready", 32'(in_ready), 32'h0);
        tick();
        chk("drain_valid", 32'(out_valid), 32'h0);

        // Reset while a beat is held discards it.
        in_valid = 4'b0001;
        tick();
        chk("pre_rst_chan", 32'(out_chan), 32'h0);
        out_ready = 1'b0;
        reset     = 1'b1;
        settle();
        chk("mid_rst_ready", 32'(in_ready), 32'h0);
        tick();
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_data",  32'(out_data),  32'h0);
        reset     = 1'b0;
        in_valid  = 4'b0000;
        out_ready = 1'b1;

        // Three-channel instance: load ch2, then out-of-range select, then wrap.
        rr3  = 1'b0;
        sel3 = 2'd2;
        v3   = 3'b111;
        settle();
        chk("n3_sel2_ready", 32'(rdy3), 32'b100);
        tick();
        chk("n3_sel2_chan", 32'(oc3), 32'h2);
        chk("n3_sel2_data", 32'(od3), 32'h0C);
        sel3 = 2'd3;
        settle();
        chk("n3_oor_ready", 32'(rdy3), 32'h0);
        tick();
        chk("n3_oor_valid", 32'(ov3), 32'h0);
        chk("n3_oor_chan",  32'(oc3), 32'h2);
        rr3 = 1'b1;
        settle();
        chk("n3_wrap_ready", 32'(rdy3), 32'b001);
        tick();
        chk("n3_wrap_chan", 32'(oc3), 32'h0);
        chk("n3_wrap_data", 32'(od3), 32'h0A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
